regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. Three requesters share the port: the ALU, the load/store unit and the multi-cycle multiply/divide unit. Each requester has one holding slot. A round-robin arbiter drains the slots into a registered write port (We/Wr/D) that drives the register file. A 32-bit pending-write scoreboard tells the issue logic which destination registers still have uncommitted writes.

## Interface
Parameters:
- DW, 32: data width
- AW, 5: register address width (2^AW registers)

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Clr  in  1  asynchronous, active-high reset
- V0, V1, V2  in  1 each  request valid: 0 = ALU, 1 = LSU, 2 = MDU
- A0, A1, A2  in  AW each  destination register of the request
- D0, D1, D2  in  DW each  write data of the request
- R0, R1, R2  out  1 each  ready; a request transfers on an edge where Vi & Ri = 1
- We  out  1  register-file write enable (registered)
- Wr  out  AW  register-file write address (registered)
- D  out  DW  register-file write data (registered)
- Gnt  out  3  one-hot source of the current We/Wr/D (registered)
- Pend  out  2^AW  bit k = 1 while a write to register k is uncommitted

## Operation
- Slot i holds full_i, addr_i and data_i. A transfer loads the slot and sets full_i.
- Ri = ~full_i | sel_i, where sel_i is this cycle's grant to slot i. A full slot that is being drained accepts a new request in the same cycle, so each requester can sustain one transfer per cycle when it wins every time.
- Arbitration is combinational over full slots and round-robin:
  - ptr (2 bits, values 0..2) names the highest-priority slot.
  - The search order is ptr, ptr+1, ptr+2, each taken mod 3.
  - The first full slot in that order wins: sel_i = 1 and full_i clears at the edge unless a new transfer refills the slot.
  - After a grant to slot i, ptr becomes (i+1) mod 3. With no grant, ptr holds.
- Output register, updated every edge:
  - On a grant: We = (addr != 0), Wr = addr, D = data, Gnt = one-hot of the winner.
  - With no grant: We = 0 and Gnt = 0; Wr and D hold their values.
  - A write to r0 is consumed normally and never asserts We.
- Pend[k] = (any full slot with addr == k) | (We & Wr == k), for k != 0. Pend[0] is always 0.
  - Pend is combinational from registered state only; it has no path from Vi, Ai or Di.
- Ordering:
  - Writes from one requester reach the register file in acceptance order.
  - Writes to the same register from different requesters have no guaranteed order. The issue logic prevents such conflicts by checking Pend.
- Vi with Ri = 0: the requester holds Vi, Ai and Di stable until the transfer completes. The arbiter does not check this.

## Timing
- Reset, asynchronous, while Clr = 1:
  - full_i = 0, ptr = 0, We = 0, Wr = 0, D = 0, Gnt = 0.
  - Therefore Ri = 1 and Pend = 0.
- Reset asserted mid-operation drops every held and in-flight write with no commit. Operation resumes on the first edge after Clr falls.
- Latency for an uncontended request:
  - Request transferred at edge T.
  - The slot wins in cycle T→T+1; We/Wr/D are valid after edge T+1.
  - The register file writes at edge T+2.
  - Pend[k] is high from just after T through just after T+2.
- Worst case: one winner per cycle and at most 2 competing slots ahead of any full slot, so a full slot is granted within 3 cycles of becoming full.
- Simultaneous events:
  - Drain and refill of the same slot in one cycle: the slot stays full with the new contents, and Pend reflects the new address.
  - Two slots holding the same address: Pend for that address stays set until both have committed.
- Throughput: one register-file write per cycle whenever any slot is full.

## Test plan
- Reset: set Clr = 1 mid-stream with all slots full → after release, We = 0, Gnt = 0, Pend = 0, R0..R2 = 1, and no write from before reset commits.
- Single ALU write: V0 = 1, A0 = 5, D0 = 32'hDEADBEEF for one cycle at edge T → We = 1, Wr = 5, D = DEADBEEF, Gnt = 001 after T+1; Pend[5] is high from T until T+2.
- Round-robin: hold all three valid continuously with distinct addresses 1/2/3 → Gnt sequence 001, 010, 100, 001, …; every Ri pulses once per 3 cycles.
- r0 suppression: V1 = 1, A1 = 0, D1 = 32'h1234 → Gnt = 010 with We = 0; Pend stays 0; register-file r0 is unchanged.
- Back-to-back with sole requester: V2 held high for 4 cycles with A2 = 7,8,9,10 → R2 stays 1 and four consecutive cycles of We = 1 with Wr = 7,8,9,10 in order.
- Contention plus refill: slot 0 full with r4 and ptr = 1, slot 1 full with r4 → slot 1 commits first, then slot 0; Pend[4] stays high until the second commit, and a new V0 accepted on slot 0's drain cycle is granted on a later cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: three one-deep
// request slots drained round-robin into a registered write port, plus a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic               Clk,
  input  logic               Clr,
  input  logic               V0,
  input  logic               V1,
  input  logic               V2,
  input  logic [AW-1:0]      A0,
  input  logic [AW-1:0]      A1,
  input  logic [AW-1:0]      A2,
  input  logic [DW-1:0]      D0,
  input  logic [DW-1:0]      D1,
  input  logic [DW-1:0]      D2,
  output logic               R0,
  output logic               R1,
  output logic               R2,
  output logic               We,
  output logic [AW-1:0]      Wr,
  output logic [DW-1:0]      D,
  output logic [2:0]         Gnt,
  output logic [2**AW-1:0]   Pend
);

  logic [2:0]    req_v;
  logic [AW-1:0] req_a [3];
  logic [DW-1:0] req_d [3];

  logic [2:0]    full_q;
  logic [AW-1:0] addr_q [3];
  logic [DW-1:0] data_q [3];
  logic [1:0]    ptr_q, ptr_d;

  logic [2:0]    sel;
  logic [2:0]    ready;
  logic [2:0]    xfer;
  logic          grant;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  assign req_v    = {V2, V1, V0};
  assign req_a[0] = A0;
  assign req_a[1] = A1;
  assign req_a[2] = A2;
  assign req_d[0] = D0;
  assign req_d[1] = D1;
  assign req_d[2] = D2;

  // A slot being drained this cycle can accept its replacement on the same edge.
  assign ready = ~full_q | sel;
  assign xfer  = req_v & ready;
  assign {R2, R1, R0} = ready;

  // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
  always_comb begin
    sel = '0;
    unique case (ptr_q)
      2'd1: begin
        sel[1] = full_q[1];
        sel[2] = full_q[2] & ~full_q[1];
        sel[0] = full_q[0] & ~full_q[1] & ~full_q[2];
      end
      2'd2: begin
        sel[2] = full_q[2];
        sel[0] = full_q[0] & ~full_q[2];
        sel[1] = full_q[1] & ~full_q[2] & ~full_q[0];
      end
      default: begin
        sel[0] = full_q[0];
        sel[1] = full_q[1] & ~full_q[0];
        sel[2] = full_q[2] & ~full_q[0] & ~full_q[1];
      end
    endcase
  end

  assign grant = |sel;

  always_comb begin
    ptr_d = ptr_q;
    if (sel[0])      ptr_d = 2'd1;
    else if (sel[1]) ptr_d = 2'd2;
    else if (sel[2]) ptr_d = 2'd0;
  end

  // sel is one-hot or zero, so an AND-OR mux picks the winner's contents.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < 3; i++) begin
      sel_addr = sel_addr | ({AW{sel[i]}} & addr_q[i]);
      sel_data = sel_data | ({DW{sel[i]}} & data_q[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      full_q <= '0;
      ptr_q  <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < 3; i++) begin
        if (xfer[i])     full_q[i] <= 1'b1;
        else if (sel[i]) full_q[i] <= 1'b0;
      end
    end
  end

  // NOTE: slot address/data are left unreset; they are only observed while full_q is set.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 3; i++) begin
      if (xfer[i]) begin
        addr_q[i] <= req_a[i];
        data_q[i] <= req_d[i];
      end
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      We  <= 1'b0;
      Wr  <= '0;
      D   <= '0;
      Gnt <= '0;
    end else if (grant) begin
      We  <= (sel_addr != '0);
      Wr  <= sel_addr;
      D   <= sel_data;
      Gnt <= sel;
    end else begin
      We  <= 1'b0;
      Gnt <= '0;
    end
  end

  // Scoreboard sees only registered state, so it never depends on this cycle's requests.
  always_comb begin
    Pend = '0;
    for (int i = 0; i < 3; i++) begin
      if (full_q[i]) Pend[addr_q[i]] = 1'b1;
    end
    if (We) Pend[Wr] = 1'b1;
    Pend[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table plus
// hand-written reset and pointer-reset sequences.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic           Clk = 1'b0;
  logic           Clr;
  logic           V0, V1, V2;
  logic [AW-1:0]  A0, A1, A2;
  logic [DW-1:0]  D0, D1, D2;
  logic           R0, R1, R2;
  logic           We;
  logic [AW-1:0]  Wr;
  logic [DW-1:0]  D;
  logic [2:0]     Gnt;
  logic [31:0]    Pend;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .Clk(Clk), .Clr(Clr),
    .V0(V0), .V1(V1), .V2(V2),
    .A0(A0), .A1(A1), .A2(A2),
    .D0(D0), .D1(D1), .D2(D2),
    .R0(R0), .R1(R1), .R2(R2),
    .We(We), .Wr(Wr), .D(D), .Gnt(Gnt), .Pend(Pend)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] d;
    logic [2:0]  gnt;
    logic [2:0]  r;
    logic [31:0] pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] v, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                              logic we, logic [4:0] wr, logic [31:0] d, logic [2:0] gnt,
                              logic [2:0] r, logic [31:0] pend);
    vec_t t;
    t.v = v; t.a0 = a0; t.a1 = a1; t.a2 = a2;
    t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.we = we; t.wr = wr; t.d = d; t.gnt = gnt; t.r = r; t.pend = pend;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2);
    {V2, V1, V0} = v;
    A0 = a0; A1 = a1; A2 = a2;
    D0 = d0; D1 = d1; D2 = d2;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Single ALU write to r5
    vecs.push_back(mk(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0,            3'b000, 3'b111, 32'h20));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0,            1, 5, 32'hDEADBEEF, 3'b001, 3'b111, 32'h20));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0,            0, 5, 32'hDEADBEEF, 3'b000, 3'b111, 32'h0));
    // LSU write to r0: granted, never written
    vecs.push_back(mk(3'b010, 0, 0, 0, 0, 32'h1234, 0,     0, 5, 32'hDEADBEEF, 3'b000, 3'b111, 32'h0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0,            0, 0, 32'h1234,     3'b010, 3'b111, 32'h0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0,            0, 0, 32'h1234,     3'b000, 3'b111, 32'h0));
    // Back-to-back MDU r7..r10
    vecs.push_back(mk(3'b100, 0, 0, 7,  0, 0, 70,          0, 0,  32'h1234,    3'b000, 3'b111, 32'h80));
    vecs.push_back(mk(3'b100, 0, 0, 8,  0, 0, 80,          1, 7,  70,          3'b100, 3'b111, 32'h180));
    vecs.push_back(mk(3'b100, 0, 0, 9,  0, 0, 90,          1, 8,  80,          3'b100, 3'b111, 32'h300));
    vecs.push_back(mk(3'b100, 0, 0, 10, 0, 0, 100,         1, 9,  90,          3'b100, 3'b111, 32'h600));
    vecs.push_back(mk(3'b000, 0, 0, 0,  0, 0, 0,           1, 10, 100,         3'b100, 3'b111, 32'h400));
    vecs.push_back(mk(3'b000, 0, 0, 0,  0, 0, 0,           0, 10, 100,         3'b000, 3'b111, 32'h0));
    // Round-robin, all three held valid
    vecs.push_back(mk(3'b111, 1, 2, 3, 11, 22, 33,         0, 10, 100,         3'b000, 3'b001, 32'hE));
    vecs.push_back(mk(3'b111, 1, 2, 3, 11, 22, 33,         1, 1,  11,          3'b001, 3'b010, 32'hE));
    vecs.push_back(mk(3'b111, 1, 2, 3, 11, 22, 33,         1, 2,  22,          3'b010, 3'b100, 32'hE));
    vecs.push_back(mk(3'b111, 1, 2, 3, 11, 22, 33,         1, 3,  33,          3'b100, 3'b001, 32'hE));
    vecs.push_back(mk(3'b111, 1, 2, 3, 11, 22, 33,         1, 1,  11,          3'b001, 3'b010, 32'hE));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0,            1, 2,  22,          3'b010, 3'b110, 32'hE));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0,            1, 3,  33,          3'b100, 3'b111, 32'hA));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0,            1, 1,  11,          3'b001, 3'b111, 32'h2));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0,            0, 1,  11,          3'b000, 3'b111, 32'h0));
    // Contention on r4 with ptr = 1, then refill of slot 0 on its drain cycle
    vecs.push_back(mk(3'b011, 4, 4, 0, 40, 41, 0,          0, 1,  11,          3'b000, 3'b110, 32'h10));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0,            1, 4,  41,          3'b010, 3'b111, 32'h10));
    vecs.push_back(mk(3'b001, 6, 0, 0, 60, 0, 0,           1, 4,  40,          3'b001, 3'b111, 32'h50));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0,            1, 6,  60,          3'b001, 3'b111, 32'h40));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0,            0, 6,  60,          3'b000, 3'b111, 32'h0));

    Clr = 1'b1;
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst.we",   64'(We),   64'(0));
    check("rst.gnt",  64'(Gnt),  64'(0));
    check("rst.pend", 64'(Pend), 64'(0));
    check("rst.r",    64'({R2, R1, R0}), 64'(3'b111));
    check("rst.wr",   64'(Wr),   64'(0));
    check("rst.d",    64'(D),    64'(0));
    @(negedge Clk);
    Clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].d0, vecs[i].d1, vecs[i].d2);
      tick();
      check($sformatf("v%0d.we", i),   64'(We),   64'(vecs[i].we));
      check($sformatf("v%0d.wr", i),   64'(Wr),   64'(vecs[i].wr));
      check($sformatf("v%0d.d", i),    64'(D),    64'(vecs[i].d));
      check($sformatf("v%0d.gnt", i),  64'(Gnt),  64'(vecs[i].gnt));
      check($sformatf("v%0d.r", i),    64'({R2, R1, R0}), 64'(vecs[i].r));
      check($sformatf("v%0d.pend", i), 64'(Pend), 64'(vecs[i].pend));
    end

    // Mid-stream reset with all three slots full (ptr = 1 going in)
    drive(3'b111, 11, 12, 13, 32'h111, 32'h222, 32'h333);
    tick();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    check("mid.pend_full", 64'(Pend), 64'(32'h3800));
    #2;
    Clr = 1'b1;
    #1;
    check("mid.we",   64'(We),   64'(0));
    check("mid.gnt",  64'(Gnt),  64'(0));
    check("mid.pend", 64'(Pend), 64'(0));
    check("mid.r",    64'({R2, R1, R0}), 64'(3'b111));
    @(posedge Clk);
    @(negedge Clk);
    Clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post%0d.we", c),   64'(We),   64'(0));
      check($sformatf("post%0d.gnt", c),  64'(Gnt),  64'(0));
      check($sformatf("post%0d.pend", c), 64'(Pend), 64'(0));
    end
    check("post.wr", 64'(Wr), 64'(0));
    check("post.d",  64'(D),  64'(0));

    // Pointer restarts at the ALU slot after reset
    drive(3'b111, 20, 21, 22, 32'hA0, 32'hA1, 32'hA2);
    tick();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    check("ptr0.gnt", 64'(Gnt), 64'(3'b001));
    check("ptr0.wr",  64'(Wr),  64'(20));
    tick();
    check("ptr1.gnt", 64'(Gnt), 64'(3'b010));
    tick();
    check("ptr2.gnt", 64'(Gnt), 64'(3'b100));
    check("ptr2.d",   64'(D),   64'(32'hA2));
    tick();
    check("drain.pend", 64'(Pend), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
